// File: rtl/seq1101_frame_tx_if.sv
// Handshake and serial-line bundle for seq1101_frame_tx.
// master: the word producer (drives in_valid/in_data, observes the line).
// slave : the framer (accepts words, drives in_ready/out/busy/frame_done).
interface seq1101_frame_tx_if #(
    parameter int DATA_W = 8
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out;
    logic              busy;
    logic              frame_done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/seq1101_frame_tx.sv
// Serializes a parallel word as a 1101-sync frame: sync, payload MSB first, optional even parity, then GAP idle bits.
// Latency: first sync bit on the line one cycle after the accepting edge; one bit per clock thereafter.
// Backpressure: in_ready only in IDLE; words offered while busy are dropped, never queued.
// Ports: clk, rst (sync, active-low), bus (slave modport: in_valid/in_data/in_ready, out/busy/frame_done).
module seq1101_frame_tx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1,
    parameter int GAP       = 1
) (
    input  logic                clk,
    input  logic                rst,
    seq1101_frame_tx_if.slave   bus
);

    // One counter serves the sync, payload and gap phases, so it is sized
    // for the longest of them and never wraps inside a frame.
    localparam int CNT_MAX = (DATA_W > GAP) ? ((DATA_W > 4) ? DATA_W : 4)
                                            : ((GAP > 4) ? GAP : 4);
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR,
        S_GAP
    } state_t;

    // state_q names the bit currently on the line; out_q is that bit.
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              par_q,   par_d;
    logic              out_q,   out_d;
    logic              fd_q,    fd_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            out_q   <= out_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        out_d   = 1'b0;
        fd_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    state_d = S_SYNC;
                    cnt_d   = '0;
                    shreg_d = bus.in_data;
                    // Parity is taken at capture; the payload shifts out later.
                    par_d   = ^bus.in_data;
                    out_d   = 1'b1;
                end
            end

            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    out_d   = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                    fd_d    = (PARITY_EN == 0) && (DATA_W == 1);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Pattern 1,1,0,1: the only zero is sync index 2.
                    out_d = (cnt_q != CNT_ONE);
                end
            end

            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (PARITY_EN != 0) begin
                        state_d = S_PAR;
                        out_d   = par_q;
                        fd_d    = 1'b1;
                    end else if (GAP > 0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    out_d   = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                    // Without parity the last payload bit closes the frame.
                    fd_d    = (PARITY_EN == 0) && (cnt_d == DATA_LAST);
                end
            end

            S_PAR: begin
                cnt_d   = '0;
                state_d = (GAP > 0) ? S_GAP : S_IDLE;
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out        = out_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seq1101_frame_tx.sv
module tb_seq1101_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq1101_frame_tx_if #(.DATA_W(8)) bus0 ();
    seq1101_frame_tx_if #(.DATA_W(8)) bus1 ();

    seq1101_frame_tx #(.DATA_W(8), .PARITY_EN(1), .GAP(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    seq1101_frame_tx #(.DATA_W(8), .PARITY_EN(0), .GAP(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Reference 1101 non-overlapping Mealy detector on dut0's line.
    typedef enum logic [1:0] {D0, D1, D11, D110} det_t;
    det_t det_st;
    logic det_hit;
    assign det_hit = (det_st == D110) && bus0.out;

    always @(posedge clk) begin
        if (!rst) det_st <= D0;
        else begin
            case (det_st)
                D0:      det_st <= bus0.out ? D1  : D0;
                D1:      det_st <= bus0.out ? D11 : D0;
                D11:     det_st <= bus0.out ? D11 : D110;
                default: det_st <= D0;
            endcase
        end
    end

    typedef struct {
        logic o;
        logic b;
        logic fd;
        logic rdy;
        logic det;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic o, input logic b, input logic fd, input logic rdy, input logic det);
        exp_t e;
        e.o = o; e.b = b; e.fd = fd; e.rdy = rdy; e.det = det;
        sb.push_back(e);
    endtask

    // Expected line activity, one entry per cycle, starting the cycle after transfer.
    task automatic push_frame(input logic [7:0] w, input bit par_en);
        logic [3:0] sync;
        sync = 4'b1101;
        for (int i = 0; i < 4; i++) push(sync[3-i], 1'b1, 1'b0, 1'b0, (i == 3));
        for (int i = 7; i >= 0; i--) push(w[i], 1'b1, (!par_en && i == 0), 1'b0, 1'b0);
        if (par_en) push(^w, 1'b1, 1'b1, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // gap
        push(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // first idle cycle
    endtask

    task automatic check_entry(input bit sel, input bit chk_det, input string tag, input int k, input exp_t e);
        chk($sformatf("%s.out[%0d]", tag, k),  sel ? bus1.out        : bus0.out,        e.o);
        chk($sformatf("%s.busy[%0d]", tag, k), sel ? bus1.busy       : bus0.busy,       e.b);
        chk($sformatf("%s.fd[%0d]", tag, k),   sel ? bus1.frame_done : bus0.frame_done, e.fd);
        chk($sformatf("%s.rdy[%0d]", tag, k),  sel ? bus1.in_ready   : bus0.in_ready,   e.rdy);
        if (chk_det) chk($sformatf("%s.det[%0d]", tag, k), det_hit, e.det);
    endtask

    task automatic drain(input bit sel, input bit chk_det, input string tag);
        exp_t e;
        int k;
        k = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            k++;
            check_entry(sel, chk_det, tag, k, e);
            @(negedge clk);
        end
    endtask

    // Called at a negedge with the selected DUT idle; returns at the negedge after transfer.
    task automatic send(input bit sel, input logic [7:0] w, input bit par_en);
        if (sel) begin bus1.in_valid = 1'b1; bus1.in_data = w; end
        else     begin bus0.in_valid = 1'b1; bus0.in_data = w; end
        @(negedge clk);
        // Changing in_data after capture must not disturb the frame.
        if (sel) begin bus1.in_valid = 1'b0; bus1.in_data = ~w; end
        else     begin bus0.in_valid = 1'b0; bus0.in_data = ~w; end
        push_frame(w, par_en);
    endtask

    function automatic logic [7:0] dval(input int c);
        return 8'((c * 37 + 11) & 255);
    endfunction

    function automatic bit has1101(input logic [8:0] bits);
        for (int i = 0; i <= 5; i++)
            if (bits[i+3 -: 4] == 4'b1101) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        exp_t e;
        logic [7:0] w;

        bus0.in_valid = 1'b0; bus0.in_data = 8'h00;
        bus1.in_valid = 1'b1; bus1.in_data = 8'hFF;   // must be ignored during reset
        rst = 1'b0;

        // Reset for two cycles, then idle.
        @(negedge clk);
        chk("rst.out",  bus0.out, 1'b0);
        chk("rst.busy", bus0.busy, 1'b0);
        chk("rst.rdy",  bus0.in_ready, 1'b1);
        chk("rst.fd",   bus0.frame_done, 1'b0);
        chk("rst.busy1", bus1.busy, 1'b0);
        @(negedge clk);
        chk("rst2.busy1", bus1.busy, 1'b0);
        rst = 1'b1;
        bus1.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle.out",  bus0.out, 1'b0);
            chk("idle.busy", bus0.busy, 1'b0);
            chk("idle.rdy",  bus0.in_ready, 1'b1);
            chk("idle.fd",   bus0.frame_done, 1'b0);
        end

        // Default frames and parity cases.
        send(1'b0, 8'hA5, 1'b1); drain(1'b0, 1'b1, "a5");
        send(1'b0, 8'h07, 1'b1); drain(1'b0, 1'b1, "p07");
        send(1'b0, 8'hFF, 1'b1); drain(1'b0, 1'b1, "pff");
        send(1'b1, 8'h07, 1'b0); drain(1'b1, 1'b0, "np07");

        // Continuous offering: transfers every 15 cycles, busy-time words dropped.
        push_frame(dval(0), 1'b1);
        push_frame(dval(15), 1'b1);
        push_frame(dval(30), 1'b1);
        bus0.in_valid = 1'b1;
        bus0.in_data  = dval(0);
        @(negedge clk);
        for (int c = 1; c <= 45; c++) begin
            e = sb.pop_front();
            check_entry(1'b0, 1'b0, "cont", c, e);
            bus0.in_data = dval(c);
            if (c == 45) bus0.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("cont.end.busy", bus0.busy, 1'b0);

        // Reset during payload bit 3 of A5: abort, no retransmission.
        send(1'b0, 8'hA5, 1'b1);
        sb.delete();
        for (int i = 1; i < 8; i++) @(negedge clk);
        chk("abort.bit3", bus0.out, 1'b0);
        chk("abort.busy_before", bus0.busy, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort.out",  bus0.out, 1'b0);
        chk("abort.busy", bus0.busy, 1'b0);
        chk("abort.rdy",  bus0.in_ready, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort.quiet.out",  bus0.out, 1'b0);
            chk("abort.quiet.busy", bus0.busy, 1'b0);
        end
        send(1'b0, 8'h3C, 1'b1); drain(1'b0, 1'b1, "post_abort");

        // Loopback into the 1101 detector with random payloads.
        for (int f = 0; f < 4; f++) begin
            w = 8'($urandom);
            while (has1101({w, ^w})) w = 8'($urandom);
            send(1'b0, w, 1'b1);
            drain(1'b0, 1'b1, $sformatf("loop%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
